// File: rtl/dsm_sample_sequencer_if.sv
// Sample handshake between the modulator datapath (master) and the
// delta-sigma sample sequencer (slave).
interface dsm_sample_sequencer_if;
    logic [7:0] SampleIn;
    logic       SampleValid;
    logic       SampleReady;

    modport master (output SampleIn, output SampleValid, input SampleReady);
    modport slave  (input SampleIn, input SampleValid, output SampleReady);
endinterface

// File: rtl/dsm_sample_sequencer.sv
// Sample sequencer feeding the transmit delta-sigma modulator: FIFO-buffered samples held OSR clocks each.
// Optional ramp in/out of the idle level is enabled by defining DSM_SEQ_RAMP_EN.
module dsm_sample_sequencer #(
    parameter int unsigned OSR        = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  IDLE_LEVEL = 8'h80
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         Enable_i,
    dsm_sample_sequencer_if.slave        smp,
    output logic [7:0]                   DsmIn_o,
    output logic                         SampleTick_o,
    output logic                         Underrun_o,
    output logic                         Active_o
);

    localparam int unsigned CNT_W = $clog2(OSR);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OSR - 1);
    localparam logic [PTR_W:0]   FILL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RAMP_UP,
        ST_RAMP_DOWN
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       dsm_q, dsm_d;
    logic             tick_q, underrun_q;
    logic             push, pop, underrun;
    logic             full, empty, boundary;
    logic [7:0]       head;
`ifdef DSM_SEQ_RAMP_EN
    logic [7:0]       target_q, target_d;

    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)      return cur + 8'd1;
        else if (cur > tgt) return cur - 8'd1;
        else                return cur;
    endfunction
`endif

    // Pop decisions use the registered fill level, so a fresh push is never popped in its own cycle.
    assign full     = (fill_q == FILL_FULL);
    assign empty    = (fill_q == '0);
    assign head     = mem_q[rd_ptr_q];
    assign boundary = (cnt_q == CNT_LAST);
    assign push     = smp.SampleValid && !full;

    assign smp.SampleReady = !full;
    assign DsmIn_o         = dsm_q;
    assign SampleTick_o    = tick_q;
    assign Underrun_o      = underrun_q;
    assign Active_o        = (state_q != ST_IDLE);

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; also decides pop and underrun events.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        pop      = 1'b0;
        underrun = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Enable_i && !empty) begin
                    pop = 1'b1;
`ifdef DSM_SEQ_RAMP_EN
                    state_d = (step_toward(IDLE_LEVEL, head) == head) ? ST_RUN : ST_RAMP_UP;
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                if (boundary) begin
                    if (!Enable_i) begin
`ifdef DSM_SEQ_RAMP_EN
                        state_d = (step_toward(dsm_q, IDLE_LEVEL) == IDLE_LEVEL) ? ST_IDLE : ST_RAMP_DOWN;
`else
                        state_d = ST_IDLE;
`endif
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        underrun = 1'b1;
                    end
                end
            end
`ifdef DSM_SEQ_RAMP_EN
            ST_RAMP_UP: begin
                if (step_toward(dsm_q, target_q) == target_q) state_d = ST_RUN;
            end
            ST_RAMP_DOWN: begin
                // Enable is deliberately ignored until the ramp reaches idle.
                if (step_toward(dsm_q, IDLE_LEVEL) == IDLE_LEVEL) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next-state: modulator code, period counter, ramp target.
    always_comb begin
        dsm_d = dsm_q;
        cnt_d = cnt_q;
`ifdef DSM_SEQ_RAMP_EN
        target_d = target_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                dsm_d = IDLE_LEVEL;
                if (pop) begin
`ifdef DSM_SEQ_RAMP_EN
                    target_d = head;
                    dsm_d    = step_toward(IDLE_LEVEL, head);
`else
                    dsm_d = head;
`endif
                end
            end
            ST_RUN: begin
                cnt_d = boundary ? '0 : cnt_q + CNT_W'(1);
                if (boundary) begin
                    if (!Enable_i) begin
`ifdef DSM_SEQ_RAMP_EN
                        dsm_d = step_toward(dsm_q, IDLE_LEVEL);
`else
                        dsm_d = IDLE_LEVEL;
`endif
                    end else if (pop) begin
                        dsm_d = head;
                    end else begin
                        dsm_d = IDLE_LEVEL;
                    end
                end
            end
`ifdef DSM_SEQ_RAMP_EN
            ST_RAMP_UP: begin
                cnt_d = '0;
                dsm_d = step_toward(dsm_q, target_q);
            end
            ST_RAMP_DOWN: begin
                cnt_d = '0;
                dsm_d = step_toward(dsm_q, IDLE_LEVEL);
            end
`endif
            default: begin
                cnt_d = '0;
                dsm_d = IDLE_LEVEL;
            end
        endcase
    end

    always_comb begin
        fill_d = fill_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + (PTR_W + 1)'(1);
            2'b01:   fill_d = fill_q - (PTR_W + 1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!Reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            cnt_q      <= '0;
            dsm_q      <= IDLE_LEVEL;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef DSM_SEQ_RAMP_EN
            target_q   <= IDLE_LEVEL;
`endif
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
            dsm_q      <= dsm_d;
            tick_q     <= pop;
            underrun_q <= underrun;
`ifdef DSM_SEQ_RAMP_EN
            target_q   <= target_d;
`endif
        end
    end

    // NOTE: the sample storage is not reset; the fill level and pointers alone define which entries are valid.
    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_ptr_q] <= smp.SampleIn;
    end

endmodule
